tl_txn_tracker: RTL and testbench

//   Synthesizable TileLink A/D/E transaction tracker for one link, probed on the same wires as the

---
 rtl/tl_txn_tracker.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_tl_txn_tracker.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_txn_tracker.sv
// ---------------------------------------------------------------------------
// tl_txn_tracker
//   TileLink A/D/E transaction tracker for a single link. It snoops the same
//   wires as the channel monitor and never drives the link itself.
//   - Frames A and D bursts: the beat count comes from opcode and size.
//     Registered first/last strobes follow each fired beat by one cycle.
//   - Keeps one table entry per source id. An A first beat allocates the
//     entry, and the D last beat retires it while reporting the latency.
//   - Counts Grants that have not yet been acknowledged on E.
//   - Flags protocol violations with a one-cycle error code and a sticky bit.
//
// Handshake: a beat transfers on a channel only in a cycle where valid and
// ready are both high at the rising clock edge. Valid without ready is a stall
// and is ignored entirely.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   a_valid/a_ready/a_opcode/a_size/a_source   channel A probe
//   d_valid/d_ready/d_opcode/d_size/d_source   channel D probe
//   e_valid/e_ready              channel E probe
//   a_first/a_last, d_first/d_last   registered burst framing strobes
//   txn_done/txn_source/txn_latency  completion pulse, source and latency
//                                    (source and latency read 0 when idle)
//   outstanding                  number of busy table entries
//   gack_pending                 Grants that are waiting for a GrantAck
//   err_valid/err_code/err_source    error pulse (code and source read 0 when idle)
//   err_sticky                   set by any error and cleared only by rst
// ---------------------------------------------------------------------------
module tl_txn_tracker #(
   parameter int SOURCE_W = 4,
   parameter int DATA_W   = 64,
   parameter int LAT_W    = 16,
   parameter int GACK_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   input  logic                a_ready,
   input  logic [2:0]          a_opcode,
   input  logic [3:0]          a_size,
   input  logic [SOURCE_W-1:0] a_source,
   input  logic                d_valid,
   input  logic                d_ready,
   input  logic [2:0]          d_opcode,
   input  logic [3:0]          d_size,
   input  logic [SOURCE_W-1:0] d_source,
   input  logic                e_valid,
   input  logic                e_ready,
   output logic                a_first,
   output logic                a_last,
   output logic                d_first,
   output logic                d_last,
   output logic                txn_done,
   output logic [SOURCE_W-1:0] txn_source,
   output logic [LAT_W-1:0]    txn_latency,
   output logic [SOURCE_W:0]   outstanding,
   output logic [GACK_W-1:0]   gack_pending,
   output logic                err_valid,
   output logic [2:0]          err_code,
   output logic [SOURCE_W-1:0] err_source,
   output logic                err_sticky
);

   localparam int NSRC   = 1 << SOURCE_W;
   localparam int LOG_BB = $clog2(DATA_W / 8);
   localparam int REM_W  = 16;   // holds beats-1 for size 15 at the smallest beat width

   localparam logic [2:0] ERR_A_SRC_BUSY    = 3'd1;
   localparam logic [2:0] ERR_D_SRC_IDLE    = 3'd2;
   localparam logic [2:0] ERR_D_OP_MISMATCH = 3'd3;
   localparam logic [2:0] ERR_BURST_BREAK   = 3'd4;
   localparam logic [2:0] ERR_E_UNEXPECTED  = 3'd5;
   localparam logic [2:0] ERR_GACK_OVF      = 3'd6;

   typedef enum logic {ST_IDLE, ST_BURST} burst_t;

   // Returns beats-1 for a message. Only data-carrying messages larger than one
   // beat span more than one beat.
   function automatic logic [REM_W-1:0] beats_m1(input logic data, input logic [3:0] size);
      logic [REM_W-1:0] r;
      r = '0;
      if (data && (int'(size) > LOG_BB))
         r = (REM_W'(1) << (int'(size) - LOG_BB)) - REM_W'(1);
      return r;
   endfunction

   // Reports whether a D opcode is a legal response to the recorded A opcode.
   function automatic logic d_op_ok(input logic [2:0] aop, input logic [2:0] dop);
      logic ok;
      case (aop)
         3'd0, 3'd1:       ok = (dop == 3'd0);
         3'd2, 3'd3, 3'd4: ok = (dop == 3'd1);
         3'd5:             ok = (dop == 3'd2);
         3'd6:             ok = (dop == 3'd4) || (dop == 3'd5);
         default:          ok = (dop == 3'd4);
      endcase
      return ok;
   endfunction

   // ---------------- A burst FSM ----------------
   burst_t                r_a_state, w_a_state_nx;
   logic [REM_W-1:0]      r_a_rem, w_a_rem_nx;
   logic [2:0]            r_a_op, w_a_op_nx;
   logic [SOURCE_W-1:0]   r_a_src, w_a_src_nx;
   logic                  w_a_fire, w_a_idle, w_a_first, w_a_last, w_a_break;
   logic [REM_W-1:0]      w_a_m1;

   assign w_a_fire  = a_valid & a_ready;
   assign w_a_idle  = (r_a_state == ST_IDLE);
   assign w_a_m1    = beats_m1(a_opcode <= 3'd3, a_size);
   assign w_a_first = w_a_fire & w_a_idle;
   // In BURST, the beat that takes the remaining count from 1 to 0 is the last beat.
   assign w_a_last  = w_a_fire & (w_a_idle ? (w_a_m1 == '0) : (r_a_rem == REM_W'(1)));
   assign w_a_break = w_a_fire & ~w_a_idle & ((a_opcode != r_a_op) | (a_source != r_a_src));

   always_comb begin
      w_a_state_nx = r_a_state;
      w_a_rem_nx   = r_a_rem;
      w_a_op_nx    = r_a_op;
      w_a_src_nx   = r_a_src;
      if (w_a_fire) begin
         if (w_a_idle) begin
            w_a_op_nx  = a_opcode;
            w_a_src_nx = a_source;
            w_a_rem_nx = w_a_m1;
            if (w_a_m1 != '0) w_a_state_nx = ST_BURST;
         end else begin
            w_a_rem_nx = r_a_rem - REM_W'(1);
            if (r_a_rem == REM_W'(1)) w_a_state_nx = ST_IDLE;
         end
      end
   end

   // ---------------- D burst FSM ----------------
   burst_t                r_d_state, w_d_state_nx;
   logic [REM_W-1:0]      r_d_rem, w_d_rem_nx;
   logic [2:0]            r_d_op, w_d_op_nx;
   logic [SOURCE_W-1:0]   r_d_src, w_d_src_nx;
   logic                  w_d_fire, w_d_idle, w_d_first, w_d_last, w_d_break;
   logic [REM_W-1:0]      w_d_m1;
   logic [2:0]            w_d_op_eff;
   logic [SOURCE_W-1:0]   w_d_src_eff;

   assign w_d_fire  = d_valid & d_ready;
   assign w_d_idle  = (r_d_state == ST_IDLE);
   assign w_d_m1    = beats_m1((d_opcode == 3'd1) || (d_opcode == 3'd5), d_size);
   assign w_d_first = w_d_fire & w_d_idle;
   assign w_d_last  = w_d_fire & (w_d_idle ? (w_d_m1 == '0) : (r_d_rem == REM_W'(1)));
   assign w_d_break = w_d_fire & ~w_d_idle & ((d_opcode != r_d_op) | (d_source != r_d_src));
   // The message identity is whatever its first beat carried.
   assign w_d_op_eff  = w_d_idle ? d_opcode : r_d_op;
   assign w_d_src_eff = w_d_idle ? d_source : r_d_src;

   always_comb begin
      w_d_state_nx = r_d_state;
      w_d_rem_nx   = r_d_rem;
      w_d_op_nx    = r_d_op;
      w_d_src_nx   = r_d_src;
      if (w_d_fire) begin
         if (w_d_idle) begin
            w_d_op_nx  = d_opcode;
            w_d_src_nx = d_source;
            w_d_rem_nx = w_d_m1;
            if (w_d_m1 != '0) w_d_state_nx = ST_BURST;
         end else begin
            w_d_rem_nx = r_d_rem - REM_W'(1);
            if (r_d_rem == REM_W'(1)) w_d_state_nx = ST_IDLE;
         end
      end
   end

   // ---------------- transaction table ----------------
   logic                  r_busy  [NSRC];
   logic [2:0]            r_op    [NSRC];
   logic [LAT_W-1:0]      r_start [NSRC];
   logic [LAT_W-1:0]      r_cnt;
   logic                  w_d_chk, w_d_idle_err, w_d_op_err, w_done, w_free_same;
   logic                  w_a_busy_err, w_alloc_new;
   logic [LAT_W-1:0]      w_lat;

   // ReleaseAck only gets framed, so it never touches the table.
   assign w_d_chk      = w_d_first & (d_opcode != 3'd6);
   assign w_d_idle_err = w_d_chk & ~r_busy[d_source];
   assign w_d_op_err   = w_d_chk & r_busy[d_source] & ~d_op_ok(r_op[d_source], d_opcode);
   assign w_done       = w_d_last & (w_d_op_eff != 3'd6) & r_busy[w_d_src_eff];
   assign w_lat        = r_cnt - r_start[w_d_src_eff];
   // A completion that frees the same source in the same cycle is treated as freeing it before the allocation.
   assign w_free_same  = w_done & (w_d_src_eff == a_source);
   assign w_a_busy_err = w_a_first & r_busy[a_source] & ~w_free_same;
   assign w_alloc_new  = w_a_first & ~(r_busy[a_source] & ~w_free_same);

   // ---------------- grant accounting ----------------
   logic                  w_g_inc, w_e_fire, w_e_unexp, w_g_ovf;
   logic [GACK_W-1:0]     w_gack_nx;

   assign w_g_inc  = w_d_first & ((d_opcode == 3'd4) || (d_opcode == 3'd5));
   assign w_e_fire = e_valid & e_ready;

   always_comb begin
      w_gack_nx = gack_pending;
      w_e_unexp = 1'b0;
      w_g_ovf   = 1'b0;
      if (w_g_inc && !w_e_fire) begin
         if (gack_pending == '1) w_g_ovf = 1'b1;
         else                    w_gack_nx = gack_pending + GACK_W'(1);
      end else if (w_e_fire && !w_g_inc) begin
         if (gack_pending == '0) w_e_unexp = 1'b1;
         else                    w_gack_nx = gack_pending - GACK_W'(1);
      end
   end

   // ---------------- error priority: lowest code wins ----------------
   logic [2:0]            w_err_code;
   logic [SOURCE_W-1:0]   w_err_src;

   always_comb begin
      w_err_code = 3'd0;
      w_err_src  = '0;
      if (w_a_busy_err) begin
         w_err_code = ERR_A_SRC_BUSY;    w_err_src = a_source;
      end else if (w_d_idle_err) begin
         w_err_code = ERR_D_SRC_IDLE;    w_err_src = d_source;
      end else if (w_d_op_err) begin
         w_err_code = ERR_D_OP_MISMATCH; w_err_src = d_source;
      end else if (w_a_break) begin
         w_err_code = ERR_BURST_BREAK;   w_err_src = a_source;
      end else if (w_d_break) begin
         w_err_code = ERR_BURST_BREAK;   w_err_src = d_source;
      end else if (w_e_unexp) begin
         w_err_code = ERR_E_UNEXPECTED;
      end else if (w_g_ovf) begin
         w_err_code = ERR_GACK_OVF;
      end
   end

   // ---------------- state and output registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_state <= ST_IDLE;  r_a_rem <= '0;  r_a_op <= '0;  r_a_src <= '0;
         r_d_state <= ST_IDLE;  r_d_rem <= '0;  r_d_op <= '0;  r_d_src <= '0;
         r_cnt <= '0;
         for (int i = 0; i < NSRC; i++) r_busy[i] <= 1'b0;
         a_first <= 1'b0;  a_last <= 1'b0;  d_first <= 1'b0;  d_last <= 1'b0;
         txn_done <= 1'b0;  txn_source <= '0;  txn_latency <= '0;
         outstanding <= '0;  gack_pending <= '0;
         err_valid <= 1'b0;  err_code <= 3'd0;  err_source <= '0;  err_sticky <= 1'b0;
      end else begin
         r_a_state <= w_a_state_nx;  r_a_rem <= w_a_rem_nx;
         r_a_op    <= w_a_op_nx;     r_a_src <= w_a_src_nx;
         r_d_state <= w_d_state_nx;  r_d_rem <= w_d_rem_nx;
         r_d_op    <= w_d_op_nx;     r_d_src <= w_d_src_nx;
         r_cnt     <= r_cnt + LAT_W'(1);
         // Free first, then allocate: on the same source, the later write wins.
         if (w_done)    r_busy[w_d_src_eff] <= 1'b0;
         if (w_a_first) r_busy[a_source]    <= 1'b1;
         a_first     <= w_a_first;
         a_last      <= w_a_last;
         d_first     <= w_d_first;
         d_last      <= w_d_last;
         txn_done    <= w_done;
         txn_source  <= w_done ? w_d_src_eff : '0;
         txn_latency <= w_done ? w_lat : '0;
         if (w_alloc_new && !w_done)      outstanding <= outstanding + (SOURCE_W+1)'(1);
         else if (w_done && !w_alloc_new) outstanding <= outstanding - (SOURCE_W+1)'(1);
         gack_pending <= w_gack_nx;
         err_valid    <= (w_err_code != 3'd0);
         err_code     <= w_err_code;
         err_source   <= w_err_src;
         err_sticky   <= err_sticky | (w_err_code != 3'd0);
      end
   end

   // Payload fields are only meaningful while busy, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_a_first) begin
         r_op[a_source]    <= a_opcode;
         r_start[a_source] <= r_cnt;
      end
   end

endmodule

// File: tb/tb_tl_txn_tracker.sv
module tb_tl_txn_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, d_valid, d_ready, e_valid, e_ready;
  logic [2:0]  a_opcode, d_opcode;
  logic [3:0]  a_size, d_size, a_source, d_source;
  logic        a_first, a_last, d_first, d_last, txn_done;
  logic [3:0]  txn_source;
  logic [15:0] txn_latency;
  logic [4:0]  outstanding;
  logic [3:0]  gack_pending;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [3:0]  err_source;
  logic        err_sticky;

  typedef struct packed {
    logic        a_first, a_last, d_first, d_last, txn_done;
    logic [3:0]  txn_source;
    logic [15:0] txn_latency;
    logic [4:0]  outstanding;
    logic [3:0]  gack_pending;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [3:0]  err_source;
    logic        err_sticky;
  } obs_t;

  typedef struct packed {
    logic       rst, a_v;
    logic [2:0] a_op;
    logic [3:0] a_sz, a_src;
    logic       d_v, d_rdy;
    logic [2:0] d_op;
    logic [3:0] d_sz, d_src;
    logic       e_v;
  } stim_t;

  localparam int OBS_W = $bits(obs_t);

  // A opcodes
  localparam int PUT_FULL = 0, GET = 4, ACQ_BLOCK = 6, ACQ_PERM = 7;
  // D opcodes
  localparam int ACK = 0, ACK_DATA = 1, GRANT = 4, GRANT_DATA = 5, RELEASE_ACK = 6;

  logic [OBS_W-1:0] exp_q[$];
  stim_t            stim_q[$];
  obs_t             obs;
  int               n_vec  = 0;
  int               n_miss = 0;

  tl_txn_tracker #(.SOURCE_W(4), .DATA_W(64), .LAT_W(16), .GACK_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source),
    .e_valid(e_valid), .e_ready(e_ready),
    .a_first(a_first), .a_last(a_last), .d_first(d_first), .d_last(d_last),
    .txn_done(txn_done), .txn_source(txn_source), .txn_latency(txn_latency),
    .outstanding(outstanding), .gack_pending(gack_pending),
    .err_valid(err_valid), .err_code(err_code), .err_source(err_source), .err_sticky(err_sticky)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

  // ---------------- stimulus / expectation builders ----------------
  function automatic stim_t st(int av, int aop, int asz, int asrc,
                               int dv, int dop, int dsz, int dsrc, int ev);
    stim_t s;
    s.rst = 1'b0;       s.a_v  = 1'(av);   s.a_op = 3'(aop);  s.a_sz = 4'(asz);
    s.a_src = 4'(asrc); s.d_v  = 1'(dv);   s.d_rdy = 1'b1;    s.d_op = 3'(dop);
    s.d_sz = 4'(dsz);   s.d_src = 4'(dsrc); s.e_v = 1'(ev);
    return s;
  endfunction

  function automatic stim_t idle_s();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t with_rst(stim_t s);
    stim_t r;
    r = s;
    r.rst = 1'b1;
    return r;
  endfunction

  function automatic stim_t no_d_ready(stim_t s);
    stim_t r;
    r = s;
    r.d_rdy = 1'b0;
    return r;
  endfunction

  function automatic obs_t ex(int af, int al, int df, int dl, int dn, int tsrc, int lat,
                              int outs, int gack, int code, int esrc, int stk);
    obs_t o;
    o.a_first = 1'(af);  o.a_last = 1'(al);  o.d_first = 1'(df);  o.d_last = 1'(dl);
    o.txn_done = 1'(dn); o.txn_source = 4'(tsrc); o.txn_latency = 16'(lat);
    o.outstanding = 5'(outs); o.gack_pending = 4'(gack);
    o.err_valid = (code != 0); o.err_code = 3'(code); o.err_source = 4'(esrc);
    o.err_sticky = 1'(stk);
    return o;
  endfunction

  task automatic sched(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic sched_reset();
    sched(with_rst(idle_s()), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    sched(with_rst(idle_s()), ex(0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  // ---------------- driver ----------------
  task automatic apply(input stim_t s);
    rst = s.rst;
    a_valid = s.a_v;  a_opcode = s.a_op;  a_size = s.a_sz;  a_source = s.a_src;  a_ready = 1'b1;
    d_valid = s.d_v;  d_opcode = s.d_op;  d_size = s.d_sz;  d_source = s.d_src;  d_ready = s.d_rdy;
    e_valid = s.e_v;  e_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    obs = {a_first, a_last, d_first, d_last, txn_done, txn_source, txn_latency,
           outstanding, gack_pending, err_valid, err_code, err_source, err_sticky};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t e;
    int   step = 0;
    // Reset with every channel firing: nothing may be flagged.
    sched(with_rst(st(1, GET, 6, 3, 1, ACK_DATA, 6, 3, 1)), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    sched(with_rst(st(1, GET, 6, 3, 1, ACK_DATA, 6, 3, 1)), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    sched(idle_s(),                   ex(0,0,0,0,0,0,0,0,0,0,0,0));
    sched(st(1, GET, 6, 3, 0,0,0,0,0), ex(1,1,0,0,0,0,0,1,0,0,0,0));
    sched(with_rst(st(0,0,0,0,0,0,0,0,1)), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    sched(idle_s(),                   ex(0,0,0,0,0,0,0,0,0,0,0,0));
    // The entry cleared by reset must now be idle.
    sched(st(0,0,0,0, 1, ACK_DATA, 3, 3, 0), ex(0,0,1,1,0,0,0,0,0,2,3,1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL reset step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_get_read();
    obs_t e;
    int   step = 0;
    sched_reset();
    sched(st(1, GET, 6, 3, 0,0,0,0,0), ex(1,1,0,0,0,0,0,1,0,0,0,0));
    for (int i = 0; i < 9; i++) sched(idle_s(), ex(0,0,0,0,0,0,0,1,0,0,0,0));
    for (int b = 1; b <= 8; b++) begin
      if (b == 5)  // one stalled cycle inside the burst
        sched(no_d_ready(st(0,0,0,0, 1, ACK_DATA, 6, 3, 0)), ex(0,0,0,0,0,0,0,1,0,0,0,0));
      if (b == 1)
        sched(st(0,0,0,0, 1, ACK_DATA, 6, 3, 0), ex(0,0,1,0,0,0,0,1,0,0,0,0));
      else if (b == 8)
        sched(st(0,0,0,0, 1, ACK_DATA, 6, 3, 0), ex(0,0,0,1,1,3,18,0,0,0,0,0));
      else
        sched(st(0,0,0,0, 1, ACK_DATA, 6, 3, 0), ex(0,0,0,0,0,0,0,1,0,0,0,0));
    end
    sched(idle_s(), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL get_read step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_put_write();
    obs_t e;
    int   step = 0;
    sched_reset();
    for (int b = 1; b <= 8; b++)
      sched(st(1, PUT_FULL, 6, 2, 0,0,0,0,0),
            ex(b == 1, b == 8, 0,0,0,0,0,1,0,0,0,0));
    sched(st(0,0,0,0, 1, ACK, 6, 2, 0), ex(0,0,1,1,1,2,8,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL put_write step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_grant();
    obs_t e;
    int   step = 0;
    sched_reset();
    sched(st(1, ACQ_BLOCK, 6, 1, 0,0,0,0,0), ex(1,1,0,0,0,0,0,1,0,0,0,0));
    for (int b = 1; b <= 8; b++)
      sched(st(0,0,0,0, 1, GRANT_DATA, 6, 1, 0),
            (b == 8) ? ex(0,0,0,1,1,1,8,0,1,0,0,0) : ex(0,0,b == 1,0,0,0,0,1,1,0,0,0));
    sched(st(0,0,0,0,0,0,0,0, 1), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    sched(st(0,0,0,0,0,0,0,0, 1), ex(0,0,0,0,0,0,0,0,0,5,0,1));
    // A Grant and a GrantAck in the same cycle leave the count at 0 and raise no error.
    sched(st(1, ACQ_PERM, 0, 2, 0,0,0,0,0), ex(1,1,0,0,0,0,0,1,0,0,0,1));
    sched(st(0,0,0,0, 1, GRANT, 0, 2, 1),   ex(0,0,1,1,1,2,1,0,0,0,0,1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL grant step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_gack_ovf();
    obs_t e;
    int   step = 0;
    sched_reset();
    for (int i = 0; i < 16; i++) begin
      sched(st(1, ACQ_PERM, 0, i, 0,0,0,0,0), ex(1,1,0,0,0,0,0,1,i,0,0,0));
      sched(st(0,0,0,0, 1, GRANT, 0, i, 0),
            ex(0,0,1,1,1,i,1,0,(i == 15) ? 15 : i + 1, (i == 15) ? 6 : 0, 0, i == 15));
    end
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL gack_ovf step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_errors();
    obs_t e;
    int   step = 0;
    sched_reset();
    sched(st(1, GET, 6, 4, 0,0,0,0,0),      ex(1,1,0,0,0,0,0,1,0,0,0,0));
    sched(st(1, GET, 6, 4, 0,0,0,0,0),      ex(1,1,0,0,0,0,0,1,0,1,4,1));
    sched(st(0,0,0,0, 1, ACK, 6, 4, 0),     ex(0,0,1,1,1,4,1,0,0,3,4,1));
    sched(st(0,0,0,0, 1, ACK_DATA, 3, 9, 0), ex(0,0,1,1,0,0,0,0,0,2,9,1));
    sched(st(1, GET, 6, 5, 0,0,0,0,0),      ex(1,1,0,0,0,0,0,1,0,0,0,1));
    // Two errors in the same cycle: the lower code (A_SRC_BUSY) is reported.
    sched(st(1, GET, 6, 5, 1, ACK_DATA, 3, 10, 0), ex(1,1,1,1,0,0,0,1,0,1,5,1));
    // ReleaseAck to an idle source is only framed.
    sched(st(0,0,0,0, 1, RELEASE_ACK, 6, 11, 0),   ex(0,0,1,1,0,0,0,1,0,0,0,1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL errors step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_burst_break();
    obs_t e;
    int   step = 0;
    sched_reset();
    for (int b = 1; b <= 8; b++)
      sched(st(1, PUT_FULL, 6, (b == 3) ? 6 : 2, 0,0,0,0,0),
            ex(b == 1, b == 8, 0,0,0,0,0,1,0, (b == 3) ? 4 : 0, (b == 3) ? 6 : 0, b >= 3));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL burst_break step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int   step = 0;
    sched_reset();
    sched(st(1, GET, 6, 7, 0,0,0,0,0),              ex(1,1,0,0,0,0,0,1,0,0,0,0));
    // The response retires the entry and a new Get re-allocates it in the same cycle.
    sched(st(1, GET, 6, 7, 1, ACK_DATA, 3, 7, 0),   ex(1,1,1,1,1,7,1,1,0,0,0,0));
    sched(st(0,0,0,0, 1, ACK_DATA, 3, 7, 0),        ex(0,0,1,1,1,7,1,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL back_to_back step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  task automatic test_wrap_and_reset();
    obs_t e;
    int   step = 0;
    // Bring the free-running counter up to 0xFFFE. The first edge after reset samples 0.
    apply(with_rst(idle_s()));
    tick();
    tick();
    apply(idle_s());
    for (int i = 0; i < 16'hFFFE; i++) tick();
    sched(st(1, GET, 6, 0, 0,0,0,0,0), ex(1,1,0,0,0,0,0,1,0,0,0,0));
    for (int i = 0; i < 4; i++) sched(idle_s(), ex(0,0,0,0,0,0,0,1,0,0,0,0));
    sched(st(0,0,0,0, 1, ACK_DATA, 3, 0, 0), ex(0,0,1,1,1,0,5,0,0,0,0,0));
    for (int b = 1; b <= 3; b++)
      sched(st(1, PUT_FULL, 6, 1, 0,0,0,0,0), ex(b == 1,0,0,0,0,0,0,1,0,0,0,0));
    sched(with_rst(st(1, PUT_FULL, 6, 1, 0,0,0,0,0)), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    sched(st(1, PUT_FULL, 6, 1, 0,0,0,0,0), ex(1,0,0,0,0,0,0,1,0,0,0,0));
    sched(with_rst(idle_s()), ex(0,0,0,0,0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      e = obs_t'(exp_q.pop_front());
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL wrap_reset step %0d: got %h expected %h", step, obs, e);
      end
      step++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    apply(with_rst(idle_s()));
    test_reset();
    test_get_read();
    test_put_write();
    test_grant();
    test_gack_ovf();
    test_errors();
    test_burst_break();
    test_back_to_back();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
